regfile_dumper: RTL and testbench
=================================

# regfile_dumper

Debug read-out engine for the 32-entry register file. On a start command it walks an inclusive address range through one register-file read port. It captures each word and streams {address, data} beats on a valid/ready interface toward the debug/trace path. It is the reader-side master for the register file's asynchronous read port and sits beside the datapath, sharing `Read_addr_1`/`Read_data_1` through the core's debug mux.

## Interface
- `bit_size`, 32, data word width (matches register file).
- `addr_size`, 5, register address width; range wraps modulo 2^addr_size.

Ports:
- `clk`  in  1  single clock; all state updates on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  dump request, sampled in IDLE only.
- `abort`  in  1  terminate dump; priority over `start`.
- `first_addr`  in  addr_size  first register to dump, latched on accepted start.
- `last_addr`  in  addr_size  last register (inclusive), latched on accepted start.
- `Read_addr`  out  addr_size  drives register-file read address.
- `Read_data`  in  bit_size  combinational read data returned by the register file.
- `dump_valid`  out  1  beat available.
- `dump_ready`  in  1  sink accepts beat.
- `dump_addr`  out  addr_size  register index of current beat.
- `dump_data`  out  bit_size  captured register value.
- `busy`  out  1  high whenever state ≠ IDLE.
- `done`  out  1  one-cycle pulse after the last beat is accepted.

## Operation
- States: IDLE, READ, SEND, DONE.
- IDLE: `start`=1 and `abort`=0 → latch `first_addr` into `cur` and `last_addr` into `end`; go to READ. `start` outside IDLE is ignored.
- READ: `Read_addr`=`cur`. At the clock edge, `dump_data`←`Read_data` and `dump_addr`←`cur`; go to SEND.
- SEND: `dump_valid`=1. Hold `dump_addr`/`dump_data` stable until `dump_valid`&&`dump_ready`.
  - On handshake with `cur`==`end` → DONE.
  - On handshake otherwise, `cur`←`cur`+1 (mod 2^addr_size) → READ.
- DONE: `done`=1 for one cycle → IDLE.
- Range: beat count is ((`end`−`first`) mod 2^addr_size)+1.
  - `first`==`last` → one beat.
  - `last`<`first` → wraps through 31→0. Example: first=30, last=1 gives 30,31,0,1.
  - A full 32-register dump is first=0, last=31, or any last=first−1.
- Snapshot semantics: each value is captured in its READ cycle. A register-file write to the same address at the same edge is not seen; the old value is emitted. Later writes do not alter a pending beat.
- `abort`=1 in READ/SEND/DONE → next state IDLE. `dump_valid` drops next cycle and no `done` pulse is issued. An abort may legally cut a pending valid beat.
- `Read_addr` holds `cur` in every state; in IDLE after reset it is 0.

## Timing
- Reset (synchronous) values:
  - state IDLE.
  - `Read_addr`, `dump_addr`, `cur`, `end` = 0.
  - `dump_data` = 0.
  - `dump_valid`, `busy`, `done` = 0.
- Reset mid-dump: all of the above take effect the cycle after the reset edge. No `done` pulse.
- Start accepted at edge E0: READ during cycle E0→E1; `dump_valid` first high after E1.
- With `dump_ready` held at 1, throughput is one beat per 2 cycles. Beat k handshakes at edge E(2k+2).
- Last beat handshake at edge Ex → `done` high from Ex to Ex+1; `busy` low after Ex+1.
- Earliest re-start: `start` sampled at Ex+1 (IDLE).
- Backpressure adds exactly one cycle per cycle that `dump_ready`=0 in SEND.

## Structure
- Shared package `regfile_pkg`: `bit_size`/`addr_size` defaults, register count (32), and the state encoding constants (IDLE=0, READ=1, SEND=2, DONE=3).
- Single flat module; no sub-module warranted. The address counter and FSM total well under 200 lines.
- Top-level instantiates the existing register file and muxes `Read_addr` onto `Read_addr_1` while `busy`=1.

## Test plan
- Preload reg[i]=0xA5000000+i. Start with first=0, last=31, ready=1 → 32 beats, addr 0..31, data 0xA5000000..0xA500001F. `done` high from E64 to E65 and `busy` low after E65.
- first=30, last=1 → beats addr 30,31,0,1 in that order, then `done`. first=last=7 → exactly one beat.
- During beat addr 5, hold `dump_ready`=0 for 3 cycles → `dump_valid`/`dump_addr`/`dump_data` stable. Beat accepted once, no duplicate. Total time +3 cycles.
- Write reg[4]=0xDEADBEEF at the same edge as the READ capture of addr 4 → beat carries the old value. The next dump shows 0xDEADBEEF.
- Abort during SEND of addr 10 → `dump_valid`=0 next cycle, `busy`=0, no `done`. `start` pulsed while busy earlier is ignored; start+abort together in IDLE → stays IDLE.
- Assert `rst` mid-dump at beat 12 → next cycle all outputs 0 and state IDLE. A fresh start then dumps from `first_addr` correctly.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared definitions for the register file and its debug read-out engine.
//   BIT_SIZE  : register word width
//   ADDR_SIZE : register address width (32 registers)
//   NUM_REGS  : number of architectural registers
//   dump_state_e : state encoding of the read-out FSM
package regfile_pkg;

  localparam int BIT_SIZE  = 32;
  localparam int ADDR_SIZE = 5;
  localparam int NUM_REGS  = 32;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_READ = 2'd1,
    ST_SEND = 2'd2,
    ST_DONE = 2'd3
  } dump_state_e;

endpackage

// File: rtl/regfile_dumper.sv
// regfile_dumper: debug read-out engine for the register file.
// Walks an inclusive, wrapping address range through one asynchronous
// register-file read port and streams {address, data} beats on a
// valid/ready interface.
//
// Ports:
//   clk, rst     : clock, synchronous active-high reset
//   start, abort : dump request (IDLE only) / terminate (priority over start)
//   first_addr   : first register to dump, latched on accepted start
//   last_addr    : last register (inclusive), latched on accepted start
//   Read_addr    : register-file read address (always the current index)
//   Read_data    : combinational register-file read data
//   dump_valid   : beat available
//   dump_ready   : sink accepts beat
//   dump_addr    : register index of the current beat
//   dump_data    : captured register value
//   busy         : high whenever the engine is not idle
//   done         : one-cycle pulse after the last beat is accepted
module regfile_dumper
  import regfile_pkg::*;
#(
  parameter int bit_size  = BIT_SIZE,
  parameter int addr_size = ADDR_SIZE
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 abort,
  input  logic [addr_size-1:0] first_addr,
  input  logic [addr_size-1:0] last_addr,
  output logic [addr_size-1:0] Read_addr,
  input  logic [bit_size-1:0]  Read_data,
  output logic                 dump_valid,
  input  logic                 dump_ready,
  output logic [addr_size-1:0] dump_addr,
  output logic [bit_size-1:0]  dump_data,
  output logic                 busy,
  output logic                 done
);

  dump_state_e state_q;
  dump_state_e state_d;

  logic [addr_size-1:0] cur_addr;
  logic [addr_size-1:0] end_addr;
  logic [addr_size-1:0] cap_addr_p1;
  logic [bit_size-1:0]  cap_data_p1;

  logic start_ok;
  logic beat_hs;
  logic at_end;

  assign start_ok = (state_q == ST_IDLE) && start && !abort;
  assign beat_hs  = (state_q == ST_SEND) && dump_ready;
  assign at_end   = (cur_addr == end_addr);

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; abort returns to IDLE from any active state
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: begin
        if (start_ok) state_d = ST_READ;
      end
      ST_READ: begin
        state_d = abort ? ST_IDLE : ST_SEND;
      end
      ST_SEND: begin
        if (abort) begin
          state_d = ST_IDLE;
        end else if (dump_ready) begin
          state_d = at_end ? ST_DONE : ST_READ;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Output decode
  always_comb begin
    dump_valid = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    unique case (state_q)
      ST_IDLE: ;
      ST_READ: busy = 1'b1;
      ST_SEND: begin
        busy       = 1'b1;
        dump_valid = 1'b1;
      end
      ST_DONE: begin
        busy = 1'b1;
        done = 1'b1;
      end
      default: ;
    endcase
  end

  // Address walker: range bounds latched on start, index advances mod
  // 2^addr_size on every non-final accepted beat.
  always_ff @(posedge clk) begin
    if (rst) begin
      cur_addr <= '0;
      end_addr <= '0;
    end else if (start_ok) begin
      cur_addr <= first_addr;
      end_addr <= last_addr;
    end else if (beat_hs && !abort && !at_end) begin
      cur_addr <= cur_addr + addr_size'(1);
    end
  end

  // Capture stage: the word is sampled at the end of READ, so a same-edge
  // register-file write is not observed and later writes cannot disturb
  // a pending beat.
  always_ff @(posedge clk) begin
    if (rst) begin
      cap_addr_p1 <= '0;
      cap_data_p1 <= '0;
    end else if (state_q == ST_READ) begin
      cap_addr_p1 <= cur_addr;
      cap_data_p1 <= Read_data;
    end
  end

  assign Read_addr = cur_addr;
  assign dump_addr = cap_addr_p1;
  assign dump_data = cap_data_p1;

endmodule

// File: tb/tb_regfile_dumper.sv
// Directed testbench for regfile_dumper with a behavioural register file.
module tb_regfile_dumper;
  import regfile_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        abort;
  logic [4:0]  first_addr;
  logic [4:0]  last_addr;
  logic [4:0]  read_addr;
  logic [31:0] read_data;
  logic        dump_valid;
  logic        dump_ready;
  logic [4:0]  dump_addr;
  logic [31:0] dump_data;
  logic        busy;
  logic        done;

  // register file model
  logic [31:0] rf [32];
  logic        preload;
  logic        we;
  logic [4:0]  wa;
  logic [31:0] wd;

  logic [31:0] exp_rf [32];
  logic [36:0] beats [$];
  int          cyc = 0;
  int          done_cnt = 0;
  int          e0;
  int          dstart;
  int          n_total = 0;
  int          n_bad = 0;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (preload) begin
      for (int i = 0; i < 32; i++) rf[i] <= 32'hA500_0000 + 32'(i);
    end else if (we) begin
      rf[wa] <= wd;
    end
  end
  assign read_data = rf[read_addr];

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (!rst && dump_valid && dump_ready) beats.push_back({dump_addr, dump_data});
    if (!rst && done) done_cnt <= done_cnt + 1;
  end

  regfile_dumper dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .abort      (abort),
    .first_addr (first_addr),
    .last_addr  (last_addr),
    .Read_addr  (read_addr),
    .Read_data  (read_data),
    .dump_valid (dump_valid),
    .dump_ready (dump_ready),
    .dump_addr  (dump_addr),
    .dump_data  (dump_data),
    .busy       (busy),
    .done       (done)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue_start(input logic [4:0] f, input logic [4:0] l);
    beats.delete();
    dstart     = done_cnt;
    first_addr = f;
    last_addr  = l;
    start      = 1'b1;
    step();
    e0    = cyc;
    start = 1'b0;
  endtask

  // Waits for done, applying an optional stall on one beat address, then
  // checks timing and the collected beat stream.
  task automatic finish_dump(input logic [4:0] f, input int nbeats, input int ncyc,
                             input logic [4:0] stall_addr, input int stall_n);
    int  stalled = 0;
    bit  seen = 0;
    logic [4:0] a;
    for (int t = 0; t < 300; t++) begin
      step();
      if (done) begin
        seen = 1;
        break;
      end
      if (dump_valid && dump_addr == stall_addr && stalled < stall_n) begin
        if (stalled > 0) begin
          check("stall_valid", 64'(dump_valid), 64'd1);
          check("stall_data", 64'(dump_data), 64'(exp_rf[stall_addr]));
        end
        dump_ready = 1'b0;
        stalled++;
      end else begin
        dump_ready = 1'b1;
      end
    end
    dump_ready = 1'b1;
    check("done_seen", 64'(seen), 64'd1);
    check("done_cycle", 64'(cyc - e0), 64'(ncyc));
    check("beat_count", 64'(beats.size()), 64'(nbeats));
    for (int i = 0; i < nbeats && i < beats.size(); i++) begin
      a = f + 5'(i);
      check($sformatf("beat%0d_addr", i), 64'(beats[i][36:32]), 64'(a));
      check($sformatf("beat%0d_data", i), 64'(beats[i][31:0]), 64'(exp_rf[a]));
    end
    step();
    check("busy_after_done", 64'(busy), 64'd0);
    check("done_one_cycle", 64'(done), 64'd0);
    check("done_pulses", 64'(done_cnt - dstart), 64'd1);
  endtask

  initial begin
    bit found;
    rst = 1'b1; preload = 1'b1; start = 1'b0; abort = 1'b0;
    first_addr = '0; last_addr = '0; dump_ready = 1'b1;
    we = 1'b0; wa = '0; wd = '0;
    for (int i = 0; i < 32; i++) exp_rf[i] = 32'hA500_0000 + 32'(i);
    step();
    step();
    preload = 1'b0;
    check("rst_read_addr", 64'(read_addr), 64'd0);
    check("rst_valid", 64'(dump_valid), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_dump_addr", 64'(dump_addr), 64'd0);
    check("rst_dump_data", 64'(dump_data), 64'd0);
    rst = 1'b0;
    step();

    // full 32-register dump: done at E64
    issue_start(5'd0, 5'd31);
    check("busy_after_start", 64'(busy), 64'd1);
    finish_dump(5'd0, 32, 64, 5'd0, 0);
    check("full_last_data", 64'(beats[31][31:0]), 64'h0000_0000_A500_001F);

    // wrapping range 30,31,0,1
    issue_start(5'd30, 5'd1);
    finish_dump(5'd30, 4, 8, 5'd0, 0);

    // single beat
    issue_start(5'd7, 5'd7);
    finish_dump(5'd7, 1, 2, 5'd0, 0);

    // backpressure on addr 5 for 3 cycles: 8 + 3
    issue_start(5'd3, 5'd6);
    finish_dump(5'd3, 4, 11, 5'd5, 3);

    // same-edge write during READ capture of addr 4: old value emitted
    issue_start(5'd4, 5'd4);
    we = 1'b1; wa = 5'd4; wd = 32'hDEAD_BEEF;
    step();
    we = 1'b0;
    e0 = e0;
    finish_dump(5'd4, 1, 2, 5'd0, 0);
    check("snap_old", 64'(beats[0][31:0]), 64'h0000_0000_A500_0004);
    exp_rf[4] = 32'hDEAD_BEEF;
    issue_start(5'd4, 5'd4);
    finish_dump(5'd4, 1, 2, 5'd0, 0);

    // abort during SEND of addr 10, with an ignored start while busy
    issue_start(5'd8, 5'd15);
    step();
    first_addr = 5'd20; last_addr = 5'd20; start = 1'b1;
    step();
    start = 1'b0;
    found = 0;
    for (int t = 0; t < 40; t++) begin
      if (dump_valid && dump_addr == 5'd10) begin
        found = 1;
        break;
      end
      step();
    end
    check("abort_reach10", 64'(found), 64'd1);
    abort = 1'b1; dump_ready = 1'b0;
    step();
    abort = 1'b0; dump_ready = 1'b1;
    check("abort_valid", 64'(dump_valid), 64'd0);
    check("abort_busy", 64'(busy), 64'd0);
    check("abort_done", 64'(done), 64'd0);
    step(); step(); step();
    check("abort_no_done", 64'(done_cnt - dstart), 64'd0);
    check("abort_beats", 64'(beats.size()), 64'd2);
    if (beats.size() == 2) begin
      check("abort_b0_addr", 64'(beats[0][36:32]), 64'd8);
      check("abort_b1_addr", 64'(beats[1][36:32]), 64'd9);
      check("abort_b1_data", 64'(beats[1][31:0]), 64'h0000_0000_A500_0009);
    end

    // start together with abort in IDLE is refused
    start = 1'b1; abort = 1'b1;
    step();
    start = 1'b0; abort = 1'b0;
    check("start_abort_busy", 64'(busy), 64'd0);
    step();
    check("start_abort_valid", 64'(dump_valid), 64'd0);

    // reset mid-dump at beat 12
    issue_start(5'd0, 5'd31);
    found = 0;
    for (int t = 0; t < 100; t++) begin
      if (dump_valid && dump_addr == 5'd12) begin
        found = 1;
        break;
      end
      step();
    end
    check("rst_reach12", 64'(found), 64'd1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("mid_rst_read_addr", 64'(read_addr), 64'd0);
    check("mid_rst_valid", 64'(dump_valid), 64'd0);
    check("mid_rst_busy", 64'(busy), 64'd0);
    check("mid_rst_done", 64'(done), 64'd0);
    check("mid_rst_dump_addr", 64'(dump_addr), 64'd0);
    check("mid_rst_dump_data", 64'(dump_data), 64'd0);
    check("mid_rst_no_done", 64'(done_cnt - dstart), 64'd0);
    issue_start(5'd2, 5'd4);
    finish_dump(5'd2, 3, 6, 5'd0, 0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
